save_ram_uploader: RTL and testbench
====================================

// Module: save_ram_uploader
// PURPOSE
//  Battery-save store for the 7800 core: High Score Cart (2 KB) or SaveKey (32 KB) RAM.
//  Serves HPS upload reads (core -> HPS), the reverse of the cart download path.
//  Accepts HPS restore writes, tracks dirty state and raises an autosave request after write-idle.
//  Sits beside the cart/BIOS dpram in the top level; the core side connects to the HSC/SaveKey bus logic.
// PARAMETERS
//  ADDR_W       15        RAM address width; 2**ADDR_W bytes.
//  AUTOSAVE_CYC 7_143_000 idle clk_sys cycles after the last core write before save_req (~1 s).
// PORTS
//  clk_sys      in  1      system clock
//  reset_n      in  1      asynchronous, active-low reset
//  save_type    in  2      header byte 58: 0=none, 1=HSC, 2=SaveKey, 3=treated as none
//  core_addr    in  ADDR_W core-side byte address
//  core_din     in  8      core write data
//  core_we      in  1      core write strobe, one byte per cycle
//  core_dout    out 8      core read data, 1-cycle latency
//  sav_load     in  1      HPS restore active (ioctl_download for the save index)
//  ioctl_upload in  1      HPS upload active
//  ioctl_rd     in  1      HPS read strobe, 1 cycle
//  ioctl_wr     in  1      HPS write strobe; honoured only while sav_load=1
//  ioctl_addr   in  25     HPS byte address
//  ioctl_dout   in  8      HPS restore data
//  ioctl_din    out 8      upload data to HPS
//  ioctl_wait   out 1      HPS must hold off while high
//  dirty        out 1      RAM differs from the last uploaded/restored image
//  save_req     out 1      one-cycle autosave request pulse
//  upload_done  out 1      one-cycle pulse on the ioctl_upload falling edge
// BEHAVIOUR
//  Reset (async assert, sync release): FSM=IDLE, ioctl_din=0, ioctl_wait=0, dirty=0, save_req=0,
//   upload_done=0, core_dout=0, idle counter=0. RAM contents are retained.
//  Active depth LIMIT: 2048 for HSC; 2**ADDR_W for SaveKey; 0 for none/3.
//  Core port:
//   - Writes are ignored when save_type is none, when core_addr>=LIMIT, or when sav_load=1.
//   - Reads return RAM data one cycle later; out-of-range reads return 8'hFF.
//  Upload FSM, states IDLE -> FETCH -> LATCH -> IDLE:
//   - IDLE: ioctl_rd with ioctl_upload=1 captures ioctl_addr and goes to FETCH.
//   - FETCH: the RAM port B read is issued.
//   - LATCH: ioctl_din takes the RAM data, or 8'hFF when addr>=LIMIT. Return to IDLE.
//   - ioctl_wait = ioctl_rd | (state!=IDLE), combinational.
//     Data is valid on the first cycle wait is low after rd: latency 3 clk_sys.
//   - ioctl_rd while not IDLE is a protocol error: ignored, no state change.
//   - ioctl_rd with ioctl_upload=0 is ignored.
//  Restore: ioctl_wr & sav_load with ioctl_addr<LIMIT writes port B. Writes at or beyond LIMIT are dropped.
//   Falling edge of sav_load clears dirty and the idle counter.
//  Dirty tracking:
//   - Every accepted core write sets dirty, including writes during an upload.
//   - The ioctl_upload falling edge pulses upload_done and clears dirty.
//     If an accepted core write occurred at any time since the ioctl_upload rising edge, dirty stays 1.
//   - An accepted core write on the same cycle as the falling edge leaves dirty=1.
//  Autosave:
//   - The idle counter resets on each accepted core write.
//   - It counts while dirty=1, ioctl_upload=0 and sav_load=0.
//   - At AUTOSAVE_CYC-1: save_req pulses once and the counter saturates (no repeat pulse)
//     until the next accepted write or a dirty clear.
//  Port collisions: port A (core) and port B (HPS) are independent; a same-address conflict is read-old-data.
//  Reset mid-upload: FSM aborts to IDLE and wait drops. The HPS reissues the read.
//  save_type change: LIMIT follows immediately; no flush.
// STRUCTURE
//  Package atari7800_save_pkg:
//   - save_type_e {SAVE_NONE, SAVE_HSC, SAVE_KEY}
//   - upl_state_e {IDLE, FETCH, LATCH}
//   - HSC_BYTES=2048
//   - function save_limit(save_type_e)
//  Sub-module save_dpram: single clock, two read/write ports, 1-cycle registered read,
//   read-old-data on collision. Infers M10K.
//  Top of this file: FSM, dirty/idle logic, port muxing.
// TESTING
//  1. HSC type; core writes 0xA5 @0x010; upload rd @0x010 -> wait high 3 cycles, ioctl_din=0xA5, dirty=0 after upload_done.
//  2. HSC type; upload rd @0x900 (>=2048) -> ioctl_din=0xFF, no RAM access. Core write @0x900 -> dirty stays 0.
//  3. SaveKey type; restore 32768 bytes of (addr^0x3C) -> core reads match pattern, dirty=0, no save_req.
//  4. AUTOSAVE_CYC=100; one core write then idle -> save_req exactly once, 99 cycles after write; none thereafter.
//  5. Core write mid-upload at the same address as a pending rd -> old data returned, dirty=1 after upload_done.
//  6. reset_n low during FETCH -> wait=0 and ioctl_din=0 immediately. Rd after release returns correct byte; RAM intact.

Source files
------------

// File: rtl/save_ram_uploader_pkg.sv
// Shared types and sizing helpers for the 7800 battery-save store.
package atari7800_save_pkg;

  typedef enum logic [1:0] {
    SAVE_NONE = 2'd0,
    SAVE_HSC  = 2'd1,
    SAVE_KEY  = 2'd2
  } save_type_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LATCH = 2'd2
  } upl_state_e;

  localparam int unsigned HSC_BYTES = 2048;

  // Number of live bytes for a save type; code 3 behaves like no save RAM.
  function automatic logic [31:0] save_limit(input save_type_e st, input int unsigned addr_w);
    case (st)
      SAVE_HSC: save_limit = 32'(HSC_BYTES);
      SAVE_KEY: save_limit = 32'd1 << addr_w;
      default:  save_limit = 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/save_ram_uploader_dpram.sv
// Single-clock true dual-port byte RAM, registered reads, read-old-data on collision.
module save_dpram #(
  parameter int ADDR_W = 15
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              en_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [7:0]        din_a,
  output logic [7:0]        q_a,
  input  logic              en_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [7:0]        din_b,
  output logic [7:0]        q_b
);

  logic [7:0] mem_r [0:(1<<ADDR_W)-1];
  logic [7:0] q_a_r;
  logic [7:0] q_b_r;

  // Array writes from both ports; contents deliberately survive reset.
  always_ff @(posedge clk_sys) begin
    if (en_a && we_a) mem_r[addr_a] <= din_a;
    if (en_b && we_b) mem_r[addr_b] <= din_b;
  end

  // Output registers sample the pre-write contents, giving read-old-data.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      q_a_r <= 8'h00;
      q_b_r <= 8'h00;
    end else begin
      if (en_a) q_a_r <= mem_r[addr_a];
      if (en_b) q_b_r <= mem_r[addr_b];
    end
  end

  assign q_a = q_a_r;
  assign q_b = q_b_r;

endmodule

// File: rtl/save_ram_uploader.sv
// HSC/SaveKey battery RAM: core port, HPS upload/restore port, dirty tracking
// and idle-timed autosave request.
module save_ram_uploader
  import atari7800_save_pkg::*;
#(
  parameter int ADDR_W       = 15,
  parameter int AUTOSAVE_CYC = 7_143_000
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [1:0]        save_type,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [7:0]        core_din,
  input  logic              core_we,
  output logic [7:0]        core_dout,
  input  logic              sav_load,
  input  logic              ioctl_upload,
  input  logic              ioctl_rd,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              dirty,
  output logic              save_req,
  output logic              upload_done
);

  localparam int CNT_W = $clog2(AUTOSAVE_CYC);
  localparam logic [CNT_W-1:0] SAT_C = CNT_W'(AUTOSAVE_CYC - 1);
  localparam logic [CNT_W-1:0] PRE_C = CNT_W'(AUTOSAVE_CYC - 2);

  upl_state_e        state_r, state_nxt_s;
  logic [24:0]       upl_addr_r;
  logic              capture_s;
  logic [7:0]        ioctl_din_r;
  logic              core_oor_r;
  logic              upl_d_r, sav_d_r;
  logic              dirty_r, dirty_nxt_s;
  logic              wrote_r, wrote_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic              save_req_r, save_nxt_s;
  logic              upload_done_r;

  logic [31:0]       limit_s;
  logic              core_in_rng_s, ioctl_in_rng_s, upl_in_rng_s;
  logic              core_acc_s, rst_wr_s;
  logic              upl_fall_s, upl_rise_s, sav_fall_s, counting_s;
  logic              ram_b_en_s, ram_b_we_s;
  logic [ADDR_W-1:0] ram_b_addr_s;
  logic [7:0]        ram_a_q_s, ram_b_q_s;

  // LIMIT tracks save_type combinationally, so a type change takes effect at once.
  assign limit_s        = save_limit(save_type_e'(save_type), ADDR_W);
  assign core_in_rng_s  = {{(32-ADDR_W){1'b0}}, core_addr} < limit_s;
  assign ioctl_in_rng_s = {7'd0, ioctl_addr} < limit_s;
  assign upl_in_rng_s   = {7'd0, upl_addr_r} < limit_s;
  assign core_acc_s     = core_we & core_in_rng_s & ~sav_load;
  assign rst_wr_s       = ioctl_wr & sav_load & ioctl_in_rng_s;
  assign upl_fall_s     = upl_d_r & ~ioctl_upload;
  assign upl_rise_s     = ~upl_d_r & ioctl_upload;
  assign sav_fall_s     = sav_d_r & ~sav_load;
  assign counting_s     = dirty_r & ~ioctl_upload & ~sav_load;

  save_dpram #(.ADDR_W(ADDR_W)) u_ram (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .en_a    (1'b1),
    .we_a    (core_acc_s),
    .addr_a  (core_addr),
    .din_a   (core_din),
    .q_a     (ram_a_q_s),
    .en_b    (ram_b_en_s),
    .we_b    (ram_b_we_s),
    .addr_b  (ram_b_addr_s),
    .din_b   (ioctl_dout),
    .q_b     (ram_b_q_s)
  );

  // Port B: restore writes take the port; otherwise it serves the upload fetch.
  always_comb begin
    ram_b_en_s   = 1'b0;
    ram_b_we_s   = 1'b0;
    ram_b_addr_s = upl_addr_r[ADDR_W-1:0];
    if (rst_wr_s) begin
      ram_b_en_s   = 1'b1;
      ram_b_we_s   = 1'b1;
      ram_b_addr_s = ioctl_addr[ADDR_W-1:0];
    end else if (state_r == FETCH) begin
      ram_b_en_s   = upl_in_rng_s;
    end else begin
      ram_b_en_s   = 1'b0;
    end
  end

  // Upload FSM next state; a read strobe outside IDLE is ignored.
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (ioctl_rd && ioctl_upload) begin
          state_nxt_s = FETCH;
          capture_s   = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FETCH:   state_nxt_s = LATCH;
      LATCH:   state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Dirty, write-since-upload-start flag and idle counter.
  always_comb begin
    dirty_nxt_s = dirty_r;
    wrote_nxt_s = wrote_r;
    cnt_nxt_s   = cnt_r;
    save_nxt_s  = 1'b0;
    if (core_acc_s) begin
      dirty_nxt_s = 1'b1;
    end else if (upl_fall_s && !sav_fall_s) begin
      dirty_nxt_s = wrote_r;
    end else if (upl_fall_s || sav_fall_s) begin
      dirty_nxt_s = 1'b0;
    end else begin
      dirty_nxt_s = dirty_r;
    end
    if (upl_rise_s) begin
      wrote_nxt_s = core_acc_s;
    end else if (core_acc_s) begin
      wrote_nxt_s = 1'b1;
    end else begin
      wrote_nxt_s = wrote_r;
    end
    // Counter saturates at SAT_C so the request fires once per idle period.
    if (core_acc_s || upl_fall_s || sav_fall_s) begin
      cnt_nxt_s = '0;
    end else if (counting_s && (cnt_r != SAT_C)) begin
      cnt_nxt_s  = cnt_r + CNT_W'(1);
      save_nxt_s = (cnt_r == PRE_C);
    end else begin
      cnt_nxt_s  = cnt_r;
    end
  end

  // State and output registers; RAM contents are not part of reset.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      upl_addr_r    <= 25'd0;
      ioctl_din_r   <= 8'h00;
      core_oor_r    <= 1'b0;
      upl_d_r       <= 1'b0;
      sav_d_r       <= 1'b0;
      dirty_r       <= 1'b0;
      wrote_r       <= 1'b0;
      cnt_r         <= '0;
      save_req_r    <= 1'b0;
      upload_done_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      if (capture_s) upl_addr_r <= ioctl_addr;
      if (state_r == LATCH) ioctl_din_r <= upl_in_rng_s ? ram_b_q_s : 8'hFF;
      core_oor_r    <= ~core_in_rng_s;
      upl_d_r       <= ioctl_upload;
      sav_d_r       <= sav_load;
      dirty_r       <= dirty_nxt_s;
      wrote_r       <= wrote_nxt_s;
      cnt_r         <= cnt_nxt_s;
      save_req_r    <= save_nxt_s;
      upload_done_r <= upl_fall_s;
    end
  end

  assign core_dout   = core_oor_r ? 8'hFF : ram_a_q_s;
  assign ioctl_din   = ioctl_din_r;
  assign ioctl_wait  = ioctl_rd | (state_r != IDLE);
  assign dirty       = dirty_r;
  assign save_req    = save_req_r;
  assign upload_done = upload_done_r;

endmodule

// File: tb/tb_save_ram_uploader.sv
// Directed bench for save_ram_uploader with a per-cycle behavioural reference model.
module tb_save_ram_uploader;

  localparam int AW = 15;
  localparam int AC = 100;

  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    save_type = 2'd0;
  logic [AW-1:0] core_addr = '0;
  logic [7:0]    core_din = 8'h00;
  logic          core_we = 1'b0;
  logic [7:0]    core_dout;
  logic          sav_load = 1'b0;
  logic          ioctl_upload = 1'b0;
  logic          ioctl_rd = 1'b0;
  logic          ioctl_wr = 1'b0;
  logic [24:0]   ioctl_addr = 25'd0;
  logic [7:0]    ioctl_dout = 8'h00;
  logic [7:0]    ioctl_din;
  logic          ioctl_wait, dirty, save_req, upload_done;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk_sys = ~clk_sys;

  save_ram_uploader #(.ADDR_W(AW), .AUTOSAVE_CYC(AC)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .save_type(save_type),
    .core_addr(core_addr), .core_din(core_din), .core_we(core_we), .core_dout(core_dout),
    .sav_load(sav_load), .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_din(ioctl_din),
    .ioctl_wait(ioctl_wait), .dirty(dirty), .save_req(save_req), .upload_done(upload_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lim_of(input logic [1:0] t);
    if (t == 2'd1) return 2048;
    else if (t == 2'd2) return 32768;
    else return 0;
  endfunction

  // Reference model: byte store plus the dirty/autosave/upload rules.
  logic [7:0] mm [0:32767];
  bit         mk [0:32767];
  int         stage = 0, pend = 0, cnt = 0;
  logic [7:0] snap = 8'h00, e_din = 8'h00, e_cd = 8'h00;
  bit         snap_k, e_din_k = 1, e_cd_k = 1;
  bit         e_dirty = 0, wrote = 0, e_save = 0, e_done = 0, upl_prev = 0, sav_prev = 0;

  always @(posedge clk_sys) begin
    int lim;
    bit acc, ufall, urise, sfall, old_dirty;
    lim = lim_of(save_type);
    if (!reset_n) begin
      stage = 0; e_din = 8'h00; e_din_k = 1; e_cd = 8'h00; e_cd_k = 1;
      e_dirty = 0; wrote = 0; cnt = 0; e_save = 0; e_done = 0; upl_prev = 0; sav_prev = 0;
    end else begin
      acc   = core_we && !sav_load && (int'(core_addr) < lim);
      ufall = upl_prev && !ioctl_upload;
      urise = !upl_prev && ioctl_upload;
      sfall = sav_prev && !sav_load;
      // Upload data is the RAM content seen one cycle after the strobe, before that cycle's writes.
      if (stage == 1) begin
        snap = mm[pend[14:0]]; snap_k = mk[pend[14:0]]; stage = 2;
      end else if (stage == 2) begin
        if (pend < lim) begin e_din = snap; e_din_k = snap_k; end
        else begin e_din = 8'hFF; e_din_k = 1; end
        stage = 0;
      end else if (ioctl_rd && ioctl_upload) begin
        pend = int'(ioctl_addr); stage = 1;
      end
      if (int'(core_addr) < lim) begin e_cd = mm[core_addr]; e_cd_k = mk[core_addr]; end
      else begin e_cd = 8'hFF; e_cd_k = 1; end
      if (acc) begin mm[core_addr] = core_din; mk[core_addr] = 1; end
      if (ioctl_wr && sav_load && (int'(ioctl_addr) < lim)) begin
        mm[ioctl_addr[14:0]] = ioctl_dout; mk[ioctl_addr[14:0]] = 1;
      end
      old_dirty = e_dirty;
      if (acc) e_dirty = 1;
      else if (ufall && !sfall) e_dirty = wrote;
      else if (ufall || sfall) e_dirty = 0;
      if (urise) wrote = acc;
      else if (acc) wrote = 1;
      e_save = 0;
      if (acc || ufall || sfall) cnt = 0;
      else if (old_dirty && !ioctl_upload && !sav_load && cnt < AC - 1) begin
        cnt++;
        e_save = (cnt == AC - 1);
      end
      e_done   = ufall;
      upl_prev = ioctl_upload;
      sav_prev = sav_load;
    end
    #1;
    chk("wait", ioctl_wait, ioctl_rd | (stage != 0));
    if (e_din_k) chk("ioctl_din", ioctl_din, e_din);
    chk("dirty", dirty, e_dirty);
    chk("save_req", save_req, e_save);
    chk("upload_done", upload_done, e_done);
    if (e_cd_k) chk("core_dout", core_dout, e_cd);
  end

  task automatic core_write(input logic [14:0] a, input logic [7:0] d);
    @(negedge clk_sys); core_addr = a; core_din = d; core_we = 1'b1;
    @(negedge clk_sys); core_we = 1'b0;
  endtask

  task automatic core_read(input logic [14:0] a, output logic [7:0] d);
    @(negedge clk_sys); core_addr = a;
    @(negedge clk_sys); d = core_dout;
  endtask

  task automatic upl_read(input logic [24:0] a, output logic [7:0] d, output int wc);
    @(negedge clk_sys); ioctl_addr = a; ioctl_rd = 1'b1; wc = 0;
    #1 if (ioctl_wait) wc++;
    @(negedge clk_sys); ioctl_rd = 1'b0; #1;
    for (int i = 0; i < 10; i++) begin
      if (!ioctl_wait) break;
      wc++;
      @(negedge clk_sys); #1;
    end
    chk("upl_wait_low", ioctl_wait, 1'b0);
    d = ioctl_din;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  d;
    logic [14:0] av;
    int          wc, n_req, first;
    int          addrs [7] = '{0, 1, 'h7FF, 'h800, 'h1234, 'h4C4C, 'h7FFF};

    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    #1;
    chk("rst_wait", ioctl_wait, 1'b0);
    chk("rst_din", ioctl_din, 8'h00);
    chk("rst_dirty", dirty, 1'b0);
    chk("rst_save_req", save_req, 1'b0);
    chk("rst_core_dout", core_dout, 8'h00);

    // 1: HSC write then upload of the same byte
    @(negedge clk_sys); save_type = 2'd1;
    core_write(15'h010, 8'hA5);
    chk("t1_dirty_set", dirty, 1'b1);
    @(negedge clk_sys); ioctl_upload = 1'b1;
    upl_read(25'h010, d, wc);
    chk("t1_din", d, 8'hA5);
    chk("t1_wait_cycles", wc, 3);
    @(negedge clk_sys); ioctl_upload = 1'b0;
    @(posedge clk_sys); #1;
    chk("t1_upload_done", upload_done, 1'b1);
    chk("t1_dirty_clear", dirty, 1'b0);

    // 2: HSC out-of-range upload and core write; 0x7FF is the last live byte
    @(negedge clk_sys); ioctl_upload = 1'b1;
    upl_read(25'h900, d, wc);
    chk("t2_din_oor", d, 8'hFF);
    @(negedge clk_sys); ioctl_upload = 1'b0;
    core_write(15'h900, 8'h11);
    chk("t2_dirty_oor", dirty, 1'b0);
    core_read(15'h900, d);
    chk("t2_core_oor", d, 8'hFF);
    core_write(15'h7FF, 8'h42);
    core_read(15'h7FF, d);
    chk("t2_core_edge", d, 8'h42);
    chk("t2_dirty_edge", dirty, 1'b1);

    // 4: autosave timing
    @(negedge clk_sys); core_addr = 15'h020; core_din = 8'h5A; core_we = 1'b1;
    @(posedge clk_sys);
    @(negedge clk_sys); core_we = 1'b0;
    n_req = 0; first = -1;
    for (int k = 1; k <= 250; k++) begin
      @(posedge clk_sys); #1;
      if (save_req) begin n_req++; if (first < 0) first = k; end
    end
    chk("t4_req_cycle", first, 99);
    chk("t4_req_count", n_req, 1);

    // 3: SaveKey full restore, plus a dropped write just past the top
    @(negedge clk_sys); save_type = 2'd2; sav_load = 1'b1;
    for (int a = 0; a < 32768; a++) begin
      av = 15'(a);
      @(negedge clk_sys); ioctl_addr = {10'd0, av}; ioctl_dout = av[7:0] ^ 8'h3C; ioctl_wr = 1'b1;
    end
    @(negedge clk_sys); ioctl_addr = 25'h8000; ioctl_dout = 8'hEE;
    @(negedge clk_sys); ioctl_wr = 1'b0; sav_load = 1'b0;
    @(posedge clk_sys); #1;
    chk("t3_dirty", dirty, 1'b0);
    n_req = 0;
    for (int k = 0; k < 150; k++) begin
      @(posedge clk_sys); #1;
      if (save_req) n_req++;
    end
    chk("t3_no_req", n_req, 0);
    foreach (addrs[i]) begin
      av = 15'(addrs[i]);
      core_read(av, d);
      chk("t3_pattern", d, av[7:0] ^ 8'h3C);
    end

    // 5: core write collides with the pending upload fetch
    @(negedge clk_sys); ioctl_upload = 1'b1; ioctl_addr = 25'h100; ioctl_rd = 1'b1;
    @(negedge clk_sys); ioctl_rd = 1'b0; core_addr = 15'h100; core_din = 8'h77; core_we = 1'b1;
    @(negedge clk_sys); core_we = 1'b0;
    @(negedge clk_sys); #1;
    chk("t5_wait", ioctl_wait, 1'b0);
    chk("t5_old_data", ioctl_din, 8'h3C);
    @(negedge clk_sys); ioctl_upload = 1'b0;
    @(posedge clk_sys); #1;
    chk("t5_upload_done", upload_done, 1'b1);
    chk("t5_dirty_kept", dirty, 1'b1);
    core_read(15'h100, d);
    chk("t5_new_data", d, 8'h77);

    // 6: reset in FETCH, then the HPS reissues the read
    @(negedge clk_sys); ioctl_upload = 1'b1; ioctl_addr = 25'h255; ioctl_rd = 1'b1;
    @(negedge clk_sys); ioctl_rd = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("t6_wait_rst", ioctl_wait, 1'b0);
    chk("t6_din_rst", ioctl_din, 8'h00);
    @(negedge clk_sys); reset_n = 1'b1;
    upl_read(25'h255, d, wc);
    chk("t6_din", d, 8'h69);
    chk("t6_wait_cycles", wc, 3);
    @(negedge clk_sys); ioctl_upload = 1'b0;
    core_read(15'h100, d);
    chk("t6_ram_kept", d, 8'h77);
    core_read(15'h7FFF, d);
    chk("t6_ram_top", d, 8'hC3);

    // save_type none: reads float high, writes are ignored
    @(negedge clk_sys); save_type = 2'd0;
    core_read(15'h010, d);
    chk("none_read", d, 8'hFF);
    core_write(15'h010, 8'h99);
    chk("none_dirty", dirty, 1'b0);

    repeat (3) @(negedge clk_sys);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
